rob_commit_buffer: RTL and testbench

- In-order commit buffer downstream of the CDB arbiter; consumes CDB broadcasts and releases results to the register file in issue order.
- Issue logic allocates one entry per issued instruction, carrying the reservation-station tag, destination register and a write flag.
- CDB results mark entries done; the head entry retires one per cycle as a registered write pulse for the register file.

---
 rtl/rob_commit_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_rob_commit_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_buffer.sv
// rob_commit_buffer
//   In-order commit buffer sitting after the CDB arbiter. Issue allocates one
//   entry per instruction (station tag, destination register, write flag).
//   CDB broadcasts mark the oldest matching undone entry as done and capture
//   its data. The head entry retires at most once per cycle as a registered
//   pulse towards the register file.
//
//   Optional build macro: ROB_CDB_BYPASS_EN
//     When defined, a CDB broadcast that completes the head entry retires it
//     at the same edge, taking the data straight from the bus.
//
// Ports
//   CLK, CLR        clock (rising edge), asynchronous active-low reset
//   flush           synchronous clear of all entries, beats every other action
//   alloc_valid/_ready, alloc_tag/_rd/_wr   allocation handshake and payload
//   alloc_idx       index the next accepted entry receives (tail pointer)
//   cdb_valid, cdb  CDB broadcast, cdb = {tag, data}
//   commit_valid/_wren/_rd/_tag/_data       registered retire outputs
//   count, full, empty                      occupancy
//   stray_cdb       sticky flag: a CDB broadcast matched no entry
module rob_commit_buffer #(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = 4,
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input  logic                      CLK,
   input  logic                      CLR,
   input  logic                      flush,
   input  logic                      alloc_valid,
   output logic                      alloc_ready,
   input  logic [TAG_W-1:0]          alloc_tag,
   input  logic [REG_W-1:0]          alloc_rd,
   input  logic                      alloc_wr,
   output logic [$clog2(DEPTH)-1:0]  alloc_idx,
   input  logic                      cdb_valid,
   input  logic [TAG_W+DATA_W-1:0]   cdb,
   output logic                      commit_valid,
   output logic                      commit_wren,
   output logic [REG_W-1:0]          commit_rd,
   output logic [TAG_W-1:0]          commit_tag,
   output logic [DATA_W-1:0]         commit_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty,
   output logic                      stray_cdb
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

   // Entry status bits (reset) and payload (no reset, only meaningful when valid)
   logic [DEPTH-1:0]  valid_reg;
   logic [DEPTH-1:0]  done_reg;
   logic [TAG_W-1:0]  tag_reg  [DEPTH];
   logic [REG_W-1:0]  rd_reg   [DEPTH];
   logic              wr_reg   [DEPTH];
   logic [DATA_W-1:0] data_reg [DEPTH];

   logic [IDX_W-1:0]  head_reg;
   logic [IDX_W-1:0]  tail_reg;
   logic [IDX_W:0]    count_reg;
   logic              stray_reg;

   logic              commit_valid_reg;
   logic              commit_wren_reg;
   logic [REG_W-1:0]  commit_rd_reg;
   logic [TAG_W-1:0]  commit_tag_reg;
   logic [DATA_W-1:0] commit_data_reg;

   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic [DEPTH-1:0]  cdb_match;
   logic              hit_found;
   logic [IDX_W-1:0]  hit_idx;
   logic [IDX_W-1:0]  probe;
   logic              full_w;
   logic              alloc_fire;
   logic              cdb_hit;
   logic              cdb_upd;
   logic              head_done;
   logic              bypass;
   logic              commit_fire;

   assign cdb_tag  = cdb[TAG_W+DATA_W-1:DATA_W];
   assign cdb_data = cdb[DATA_W-1:0];

   // Candidate entries for this broadcast. An entry allocated in this same
   // cycle is still invalid here, so it can never be picked.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         assign cdb_match[gi] = valid_reg[gi] & ~done_reg[gi] & (tag_reg[gi] == cdb_tag);
      end
   endgenerate

   // Oldest match: scan in age order starting at head, wrapping modulo DEPTH.
   always_comb begin
      hit_found = 1'b0;
      hit_idx   = head_reg;
      probe     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         probe = head_reg + IDX_W'(k);
         if (!hit_found && cdb_match[probe]) begin
            hit_found = 1'b1;
            hit_idx   = probe;
         end
      end
   end

   assign full_w     = (count_reg == DEPTH_C);
   // No look-ahead: a full buffer refuses even when the head retires this cycle.
   assign alloc_fire = alloc_valid & ~full_w;
   assign cdb_hit    = cdb_valid & hit_found;
   assign head_done  = valid_reg[head_reg] & done_reg[head_reg];

`ifdef ROB_CDB_BYPASS_EN
   // The oldest match being the head means the head is valid and undone.
   assign bypass = cdb_hit & (hit_idx == head_reg);
`else
   assign bypass = 1'b0;
`endif

   assign commit_fire = head_done | bypass;
   // A bypassed broadcast retires the entry directly; nothing to mark done.
   assign cdb_upd     = cdb_hit & ~bypass;

   // Status bits. Alloc writes the tail slot, which is never the committing
   // head nor a CDB target (both require a valid slot, tail is free unless full).
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         valid_reg <= '0;
         done_reg  <= '0;
      end else if (flush) begin
         valid_reg <= '0;
         done_reg  <= '0;
      end else begin
         if (cdb_upd)
            done_reg[hit_idx] <= 1'b1;
         if (commit_fire)
            valid_reg[head_reg] <= 1'b0;
         if (alloc_fire) begin
            valid_reg[tail_reg] <= 1'b1;
            done_reg[tail_reg]  <= 1'b0;
         end
      end
   end

   // Payload storage; stale contents are harmless since valid gates every use.
   always_ff @(posedge CLK) begin
      if (alloc_fire) begin
         tag_reg[tail_reg] <= alloc_tag;
         rd_reg[tail_reg]  <= alloc_rd;
         wr_reg[tail_reg]  <= alloc_wr;
      end
      if (cdb_upd)
         data_reg[hit_idx] <= cdb_data;
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         stray_reg        <= 1'b0;
         commit_valid_reg <= 1'b0;
         commit_wren_reg  <= 1'b0;
         commit_rd_reg    <= '0;
         commit_tag_reg   <= '0;
         commit_data_reg  <= '0;
      end else if (flush) begin
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         stray_reg        <= 1'b0;
         commit_valid_reg <= 1'b0;
         commit_wren_reg  <= 1'b0;
         commit_rd_reg    <= '0;
         commit_tag_reg   <= '0;
         commit_data_reg  <= '0;
      end else begin
         if (alloc_fire)
            tail_reg <= tail_reg + 1'b1;
         if (commit_fire)
            head_reg <= head_reg + 1'b1;
         case ({alloc_fire, commit_fire})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (cdb_valid && !hit_found)
            stray_reg <= 1'b1;
         commit_valid_reg <= commit_fire;
         commit_wren_reg  <= commit_fire & wr_reg[head_reg];
         if (commit_fire) begin
            commit_rd_reg   <= rd_reg[head_reg];
            commit_tag_reg  <= tag_reg[head_reg];
            commit_data_reg <= bypass ? cdb_data : data_reg[head_reg];
         end
      end
   end

   assign alloc_ready  = ~full_w;
   assign alloc_idx    = tail_reg;
   assign count        = count_reg;
   assign full         = full_w;
   assign empty        = (count_reg == '0);
   assign stray_cdb    = stray_reg;
   assign commit_valid = commit_valid_reg;
   assign commit_wren  = commit_wren_reg;
   assign commit_rd    = commit_rd_reg;
   assign commit_tag   = commit_tag_reg;
   assign commit_data  = commit_data_reg;

endmodule

// File: tb/tb_rob_commit_buffer.sv
// tb_rob_commit_buffer
//   Scoreboard bench: a behavioural queue of outstanding entries models the
//   buffer; whenever a broadcast completes the oldest entry, finished entries
//   are pushed to the expected-commit queue, which a monitor pops on every
//   observed commit pulse.
module tb_rob_commit_buffer;

   localparam int DEPTH  = 8;
   localparam int TAG_W  = 4;
   localparam int DATA_W = 16;
   localparam int REG_W  = 3;
`ifdef ROB_CDB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                    CLK = 1'b0;
   logic                    CLR = 1'b0;
   logic                    flush = 1'b0;
   logic                    alloc_valid = 1'b0;
   logic                    alloc_ready;
   logic [TAG_W-1:0]        alloc_tag = '0;
   logic [REG_W-1:0]        alloc_rd = '0;
   logic                    alloc_wr = 1'b0;
   logic [2:0]              alloc_idx;
   logic                    cdb_valid = 1'b0;
   logic [TAG_W+DATA_W-1:0] cdb = '0;
   logic                    commit_valid;
   logic                    commit_wren;
   logic [REG_W-1:0]        commit_rd;
   logic [TAG_W-1:0]        commit_tag;
   logic [DATA_W-1:0]       commit_data;
   logic [3:0]              count;
   logic                    full;
   logic                    empty;
   logic                    stray_cdb;

   rob_commit_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .CLK(CLK), .CLR(CLR), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .alloc_rd(alloc_rd), .alloc_wr(alloc_wr), .alloc_idx(alloc_idx),
      .cdb_valid(cdb_valid), .cdb(cdb),
      .commit_valid(commit_valid), .commit_wren(commit_wren), .commit_rd(commit_rd),
      .commit_tag(commit_tag), .commit_data(commit_data),
      .count(count), .full(full), .empty(empty), .stray_cdb(stray_cdb)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [REG_W-1:0]  rd;
      logic              wr;
      logic [DATA_W-1:0] data;
      logic              done;
   } ent_t;

   ent_t mq[$];      // outstanding (not yet handed to the scoreboard) entries
   ent_t exp_q[$];   // expected commits, in order
   ent_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   m_tail = 0;
   logic m_stray = 1'b0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Commit monitor: every pulse must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (mon_en && CLR) begin
         if (commit_valid) begin
            if (exp_q.size() == 0) begin
               chk("commit_unexpected", 32'(commit_valid), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("commit_tag", 32'(commit_tag), 32'(mon_e.tag));
               chk("commit_rd", 32'(commit_rd), 32'(mon_e.rd));
               chk("commit_wren", 32'(commit_wren), 32'(mon_e.wr));
               chk("commit_data", 32'(commit_data), 32'(mon_e.data));
               $display("commit tag=%0h rd=%0d wren=%0b data=%04h",
                        commit_tag, commit_rd, commit_wren, commit_data);
            end
         end else begin
            chk("idle_wren", 32'(commit_wren), 32'd0);
         end
      end
   end

   task automatic alloc(input logic [TAG_W-1:0] t, input logic [REG_W-1:0] rd, input logic wr);
      bit   acc;
      ent_t e;
      acc = (mq.size() + exp_q.size()) < DEPTH;
      chk("alloc_ready", 32'(alloc_ready), 32'(acc));
      chk("alloc_idx", 32'(alloc_idx), 32'(m_tail));
      alloc_valid = 1'b1;
      alloc_tag   = t;
      alloc_rd    = rd;
      alloc_wr    = wr;
      tick();
      alloc_valid = 1'b0;
      if (acc) begin
         e = '0;
         e.tag = t;
         e.rd  = rd;
         e.wr  = wr;
         mq.push_back(e);
         m_tail = (m_tail + 1) % DEPTH;
      end
      $display("alloc tag=%0h rd=%0d wr=%0b %s", t, rd, wr, acc ? "accepted" : "refused");
   endtask

   task automatic cdb_send(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      int   hit;
      ent_t e;
      hit = -1;
      for (int i = 0; i < mq.size(); i++)
         if (hit < 0 && !mq[i].done && mq[i].tag == t) hit = i;
      if (hit >= 0) begin
         e = mq[hit];
         e.done = 1'b1;
         e.data = d;
         mq[hit] = e;
      end else begin
         m_stray = 1'b1;
      end
      while (mq.size() > 0 && mq[0].done) exp_q.push_back(mq.pop_front());
      cdb_valid = 1'b1;
      cdb = {t, d};
      tick();
      cdb_valid = 1'b0;
      $display("cdb tag=%0h data=%04h %s", t, d, (hit >= 0) ? "match" : "stray");
   endtask

   // Wait (bounded) for all expected commits, then check occupancy and flags.
   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < 30) begin
         @(negedge CLK);
         k++;
      end
      tick();
      chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_count"}, 32'(count), 32'(mq.size()));
      chk({name, "_empty"}, 32'(empty), 32'(mq.size() == 0));
      chk({name, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
      chk({name, "_stray"}, 32'(stray_cdb), 32'(m_stray));
   endtask

   task automatic flush_dut();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      mq.delete();
      exp_q.delete();
      m_tail  = 0;
      m_stray = 1'b0;
      $display("flush");
   endtask

   task automatic cleared(input string name);
      chk({name, "_count"}, 32'(count), 32'd0);
      chk({name, "_empty"}, 32'(empty), 32'd1);
      chk({name, "_cvalid"}, 32'(commit_valid), 32'd0);
      chk({name, "_stray"}, 32'(stray_cdb), 32'd0);
      chk({name, "_idx"}, 32'(alloc_idx), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] pat;
      // Reset state
      repeat (3) tick();
      cleared("rst");
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ready", 32'(alloc_ready), 32'd1);
      CLR = 1'b1;
      tick();
      mon_en = 1'b1;

      // Single instruction, latency check
      alloc(4'd1, 3'd2, 1'b1);
      cdb_send(4'd1, 16'h00AA);
      chk("lat_e", 32'(commit_valid), 32'(BYP));
      tick();
      chk("lat_e1", 32'(commit_valid), 32'(!BYP));
      chk("lat_e1_wren", 32'(commit_wren), 32'(!BYP));
      tick();
      chk("pulse_end", 32'(commit_valid), 32'd0);
      drain("t1");

      // Out-of-order completion, in-order consecutive retire
      alloc(4'd1, 3'd1, 1'b1);
      alloc(4'd5, 3'd2, 1'b1);
      alloc(4'd2, 3'd3, 1'b1);
      cdb_send(4'd2, 16'd30);
      cdb_send(4'd5, 16'd20);
      cdb_send(4'd1, 16'd10);
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         pat = {pat[4:0], commit_valid};
      end
      chk("consec", 32'(pat), BYP ? 32'h38 : 32'h1C);
      drain("t2");

      // Fill to full, refuse the 9th, wrap the tail
      flush_dut();
      for (int i = 0; i < DEPTH; i++) alloc(4'(8 + i), 3'(i), 1'b1);
      chk("full", 32'(full), 32'd1);
      chk("full_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(count), 32'd8);
      alloc(4'hF, 3'd0, 1'b1);
      chk("refused_count", 32'(count), 32'd8);
      cdb_send(4'd8, 16'h1000);
      drain("t3a");
      alloc(4'd3, 3'd7, 1'b1);
      chk("wrap_idx", 32'(alloc_idx), 32'd1);
      for (int i = 1; i < DEPTH; i++) cdb_send(4'(8 + i), 16'(16'h1000 + i));
      cdb_send(4'd3, 16'h2000);
      drain("t3b");

      // Duplicate tags: oldest match only
      alloc(4'd5, 3'd4, 1'b1);
      alloc(4'd5, 3'd5, 1'b1);
      cdb_send(4'd5, 16'd7);
      drain("t4a");
      cdb_send(4'd5, 16'd9);
      drain("t4b");

      // Store commit and stray broadcast
      alloc(4'd6, 3'd6, 1'b0);
      cdb_send(4'd6, 16'h0066);
      drain("t5a");
      cdb_send(4'd3, 16'h0033);
      drain("t5b");
      repeat (3) tick();
      chk("stray_sticky", 32'(stray_cdb), 32'd1);

      // Flush with pending entries
      for (int i = 0; i < 4; i++) alloc(4'(1 + i), 3'(i), 1'b1);
      flush_dut();
      cleared("flush");
      for (int i = 0; i < 4; i++) alloc(4'(1 + i), 3'(i), 1'b1);
      cdb_send(4'hE, 16'h0EEE);
      chk("pre_clr_stray", 32'(stray_cdb), 32'd1);

      // Asynchronous reset mid-cycle with pending entries
      CLR = 1'b0;
      #2;
      cleared("clr");
      mq.delete();
      exp_q.delete();
      m_tail  = 0;
      m_stray = 1'b0;
      tick();
      CLR = 1'b1;
      alloc(4'd7, 3'd1, 1'b1);
      cdb_send(4'd7, 16'h0777);
      drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
